// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - shared mode encodings and default widths for the immediate extender
//
// Purpose: mode encodings and default parameter values used by imm_ext_core,
//          imm_extend_pipe_if and imm_extend_pipe.
// Ports:   none (package).
// Config:  IMM_EXT_SHIFT_EN selects whether MODE_UPPER/MODE_BR2 are implemented.

package imm_ext_pkg;

   typedef enum logic [1:0] {
      MODE_SEXT  = 2'b00,   // sign-extend
      MODE_ZEXT  = 2'b01,   // zero-extend
      MODE_UPPER = 2'b10,   // immediate in the upper bits, low bits zero
      MODE_BR2   = 2'b11    // sign-extend then shift left by 2
   } imm_mode_e;

   localparam int IMM_IN_W_DEF  = 16;
   localparam int IMM_OUT_W_DEF = 32;
   localparam int IMM_DEPTH_DEF = 2;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - write/read handshake bundle of the immediate extender
//
// Purpose: groups the producer-side (in_*) and consumer-side (out_*) handshake
//          signals of imm_extend_pipe.
// Modports:
//   master - testbench/surrounding logic view: drives in_valid/in_imm/in_mode/out_ready
//   slave  - imm_extend_pipe view: drives in_ready/out_valid/out_imm/out_count

interface imm_extend_pipe_if
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W_DEF,
   parameter int OUT_W = IMM_OUT_W_DEF,
   parameter int DEPTH = IMM_DEPTH_DEF
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_imm;
   logic [CW-1:0]    out_count;

   modport master (
      output in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_imm, out_count
   );

   modport slave (
      input  in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_imm, out_count
   );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// rtl/imm_extend_pipe_core.sv - combinational immediate extend/shift
//
// Purpose: turns an IN_W-bit immediate into an OUT_W-bit operand according to mode.
// Config:  IMM_EXT_SHIFT_EN defined -> all four modes; undefined -> mode_i[1]
//          ignored (10 acts as 00, 11 as 01) and the upper/shift paths are absent.
// Ports:
//   imm_i  [IN_W]  raw immediate
//   mode_i [2]     extension mode (imm_mode_e encoding)
//   ext_o  [OUT_W] extended result

module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W_DEF,
   parameter int OUT_W = IMM_OUT_W_DEF
) (
   input  logic [IN_W-1:0]  imm_i,
   input  logic [1:0]       mode_i,
   output logic [OUT_W-1:0] ext_o
);
   localparam int PAD_W = OUT_W - IN_W;

   logic [OUT_W-1:0] sext_res;
   logic [OUT_W-1:0] zext_res;

   assign sext_res = {{PAD_W{imm_i[IN_W-1]}}, imm_i};
   assign zext_res = {{PAD_W{1'b0}}, imm_i};

`ifdef IMM_EXT_SHIFT_EN
   logic [OUT_W-1:0] upper_res;
   logic [OUT_W-1:0] br2_res;

   assign upper_res = {imm_i, {PAD_W{1'b0}}};
   // Branch offset: the two MSBs of the sign-extended value fall off the top.
   assign br2_res   = {sext_res[OUT_W-3:0], 2'b00};

   always_comb begin
      ext_o = sext_res;
      case (mode_i)
         MODE_SEXT:  ext_o = sext_res;
         MODE_ZEXT:  ext_o = zext_res;
         MODE_UPPER: ext_o = upper_res;
         MODE_BR2:   ext_o = br2_res;
         default:    ext_o = sext_res;
      endcase
   end
`else
   // Only the sign/zero choice exists; the upper mode bit has no effect.
   logic unused_mode_hi;
   assign unused_mode_hi = mode_i[1];
   assign ext_o = mode_i[0] ? zext_res : sext_res;
`endif

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - buffered immediate extender between decode and ALU operand mux
//
// Purpose: extends each accepted immediate on the write side and queues the
//          OUT_W-bit results in a DEPTH-entry FIFO so decode can run ahead of a
//          stalled execute stage.
// Config:  IMM_EXT_SHIFT_EN enables modes 10 (upper) and 11 (branch shift-by-2).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards all buffered entries
//   flush  synchronous clear of all entries; wins over a same-cycle push/pop
//   bus    imm_extend_pipe_if.slave: in_valid/in_ready/in_imm/in_mode push side,
//          out_valid/out_ready/out_imm pop side, out_count occupancy

module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W_DEF,
   parameter int OUT_W = IMM_OUT_W_DEF,
   parameter int DEPTH = IMM_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   imm_extend_pipe_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic [OUT_W-1:0] mem_q [DEPTH];
   logic [OUT_W-1:0] ext_res;
   logic             can_push;
   logic             has_data;
   logic             push;
   logic             pop;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm_i  (bus.in_imm),
      .mode_i (bus.in_mode),
      .ext_o  (ext_res)
   );

   // Both handshake flags come from count_q only, so in_ready never depends
   // combinationally on out_ready and only moves on an edge or reset.
   assign can_push = (count_q < FULL_CNT);
   assign has_data = (count_q != '0);
   assign push     = bus.in_valid && can_push;
   assign pop      = has_data && bus.out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer wrap is plain overflow.
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: stale entries are never visible because out_imm
   // is forced to zero whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= ext_res;
   end

   assign bus.in_ready  = can_push;
   assign bus.out_valid = has_data;
   assign bus.out_imm   = has_data ? mem_q[rd_ptr_q] : '0;
   assign bus.out_count = count_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe

module tb_imm_extend_pipe;
   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [OUT_W-1:0] mq[$];
   logic [OUT_W-1:0] exp_mode [4];

   imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus_if ();

   imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Arithmetic reference: treat the immediate as a number, scale it, reduce mod 2^OUT_W.
   function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] imm, input logic [1:0] mode);
      longint u, s, r, span_in;
      logic [1:0] m;
      u = longint'(imm);
      span_in = longint'(1) << IN_W;
      s = (u >= span_in / 2) ? u - span_in : u;
      m = mode;
`ifndef IMM_EXT_SHIFT_EN
      m = {1'b0, mode[0]};
`endif
      case (m)
         2'd0:    r = s;
         2'd1:    r = u;
         2'd2:    r = u * (longint'(1) << (OUT_W - IN_W));
         default: r = s * 4;
      endcase
      return OUT_W'(r);
   endfunction

   // Called just after a rising edge: drive, check outputs before the next edge
   // against the queue model, then advance the model across that edge.
   task automatic step(input logic v, input logic [IN_W-1:0] imm, input logic [1:0] mode,
                       input logic ordy, input logic fl);
      logic do_push, do_pop;
      bus_if.in_valid  = v;
      bus_if.in_imm    = imm;
      bus_if.in_mode   = mode;
      bus_if.out_ready = ordy;
      flush            = fl;
      @(negedge clk);
      check("in_ready",  64'(bus_if.in_ready),  64'(mq.size() < DEPTH));
      check("out_valid", 64'(bus_if.out_valid), 64'(mq.size() != 0));
      check("out_count", 64'(bus_if.out_count), 64'(mq.size()));
      check("out_imm",   64'(bus_if.out_imm),   (mq.size() != 0) ? 64'(mq[0]) : 64'(0));
      do_push = v && (mq.size() < DEPTH);
      do_pop  = ordy && (mq.size() != 0);
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(ref_ext(imm, mode));
      end
      #1;
      bus_if.in_valid = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
`ifdef IMM_EXT_SHIFT_EN
      exp_mode[0] = 32'hFFFF8004; exp_mode[1] = 32'h00008004;
      exp_mode[2] = 32'h80040000; exp_mode[3] = 32'hFFFE0010;
`else
      exp_mode[0] = 32'hFFFF8004; exp_mode[1] = 32'h00008004;
      exp_mode[2] = 32'hFFFF8004; exp_mode[3] = 32'h00008004;
`endif
      bus_if.in_valid = 1'b0; bus_if.in_imm = '0; bus_if.in_mode = '0; bus_if.out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
      check("rst_out_count", 64'(bus_if.out_count), 64'(0));
      check("rst_in_ready",  64'(bus_if.in_ready),  64'(1));
      check("rst_out_imm",   64'(bus_if.out_imm),   64'(0));
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Each mode on 0x8004, result visible right after the accepting edge
      for (int m = 0; m < 4; m++) begin
         step(1'b1, 16'h8004, 2'(m), 1'b0, 1'b0);
         check($sformatf("mode%0d_imm", m), 64'(bus_if.out_imm), 64'(exp_mode[m]));
         check($sformatf("mode%0d_valid", m), 64'(bus_if.out_valid), 64'(1));
         step(1'b0, '0, 2'd0, 1'b1, 1'b0);
      end

      // Backpressure: third item held while full, then drained in order
      step(1'b1, 16'h1111, 2'd0, 1'b0, 1'b0);
      step(1'b1, 16'h2222, 2'd1, 1'b0, 1'b0);
      step(1'b1, 16'h3333, 2'd0, 1'b0, 1'b0);
      check("bp_count_full", 64'(bus_if.out_count), 64'(2));
      check("bp_in_ready",   64'(bus_if.in_ready),  64'(0));
      step(1'b1, 16'h3333, 2'd0, 1'b1, 1'b0);
      step(1'b1, 16'h3333, 2'd0, 1'b1, 1'b0);
      step(1'b0, '0, 2'd0, 1'b1, 1'b0);
      step(1'b0, '0, 2'd0, 1'b1, 1'b0);
      check("bp_drained", 64'(bus_if.out_count), 64'(0));

      // Full with pop requested: push blocked, count drops
      step(1'b1, 16'hA001, 2'd0, 1'b0, 1'b0);
      step(1'b1, 16'hA002, 2'd0, 1'b0, 1'b0);
      step(1'b1, 16'hA003, 2'd0, 1'b1, 1'b0);
      check("full_pop_count", 64'(bus_if.out_count), 64'(1));
      // Count 1: push+pop every cycle across pointer wrap
      for (int i = 0; i < 10; i++) step(1'b1, 16'(16'hB000 + i), 2'(i), 1'b1, 1'b0);
      check("pp_count_same", 64'(bus_if.out_count), 64'(1));
      step(1'b0, '0, 2'd0, 1'b1, 1'b0);

      // Flush at count 2 with push and pop requested
      step(1'b1, 16'hC001, 2'd1, 1'b0, 1'b0);
      step(1'b1, 16'hC002, 2'd1, 1'b0, 1'b0);
      step(1'b1, 16'hC003, 2'd1, 1'b1, 1'b1);
      check("flush_count", 64'(bus_if.out_count), 64'(0));
      check("flush_valid", 64'(bus_if.out_valid), 64'(0));
      step(1'b0, '0, 2'd0, 1'b0, 1'b0);

      // Reset mid-stream with 2 entries: outputs clear without waiting for an edge
      step(1'b1, 16'hD001, 2'd0, 1'b0, 1'b0);
      step(1'b1, 16'hD002, 2'd0, 1'b0, 1'b0);
      @(negedge clk); #1 rst_n = 1'b0; #1;
      mq.delete();
      check("mid_rst_valid", 64'(bus_if.out_valid), 64'(0));
      check("mid_rst_count", 64'(bus_if.out_count), 64'(0));
      check("mid_rst_ready", 64'(bus_if.in_ready),  64'(1));
      check("mid_rst_imm",   64'(bus_if.out_imm),   64'(0));
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      step(1'b1, 16'h0001, 2'd0, 1'b0, 1'b0);
      check("post_rst_imm", 64'(bus_if.out_imm), 64'h1);
      step(1'b0, '0, 2'd0, 1'b1, 1'b0);

      // Randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
